// File: rtl/memShare_config_pkg.sv
// Shared configuration for the message-pass buffer write side:
// writer state encoding, write-enable polarity and default buffer depth.
package memShare_config_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        DRAIN = 2'd2
    } wb_state_e;

    localparam logic MSGPASS_BUFF_WR_DISABLE = 1'b0;
    localparam logic MSGPASS_BUFF_WR_ENABLE  = 1'b1;

    localparam int MSGPASS_BUFF_DEPTH = 8;

endpackage

// File: rtl/msgpass_wb_fifo.sv
// Small synchronous input queue for the buffer writer.
// DEPTH must be a power of two (pointers wrap naturally). The caller never
// pops when empty and only pushes into a full queue together with a pop.
module msgpass_wb_fifo #(
    parameter int W     = 20,
    parameter int DEPTH = 2
) (
    input  logic         sys_clk,
    input  logic         rstn,
    input  logic         i_push,
    input  logic         i_pop,
    input  logic [W-1:0] i_data,
    output logic [W-1:0] o_head,
    output logic         o_full,
    output logic         o_empty
);

    localparam int PW = $clog2(DEPTH);

    logic [W-1:0]  r_mem [DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [PW:0]   r_count;

    // Storage array; contents are meaningless until pushed, so no reset.
    always_ff @(posedge sys_clk) begin
        if (i_push) r_mem[r_wr_ptr] <= i_data;
    end

    // Read/write pointers and occupancy.
    always_ff @(posedge sys_clk or negedge rstn) begin
        if (!rstn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) r_wr_ptr <= r_wr_ptr + PW'(1);
            if (i_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + (PW+1)'(1);
                2'b01:   r_count <= r_count - (PW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_head  = r_mem[r_rd_ptr];
    assign o_full  = (r_count == (PW+1)'(DEPTH));
    assign o_empty = (r_count == '0);

endmodule

// File: rtl/msgpass_buff_writer.sv
// Write-side controller of the message-pass buffer.
// Queues V2C vectors and writes them to port A at sequential addresses
// between write_begin_i and write_end_i, absorbing port-conflict stalls.
// Optional macro MSGPASS_WB_ADDR_LIMIT_EN: no address wrap; after writing
// address BUFF_DEPTH-1, issues stop, later pushes are dropped and DRAIN
// discards leftover queue entries one per cycle.
module msgpass_buff_writer
    import memShare_config_pkg::*;
#(
    parameter int V2C_VEC_WIDTH = 20,
    parameter int BUFF_DEPTH    = MSGPASS_BUFF_DEPTH,
    parameter int ADDR_WIDTH    = 3,
    parameter int FIFO_DEPTH    = 2,
    parameter int CNT_WIDTH     = 8
) (
    input  logic                     sys_clk,
    input  logic                     rstn,
    input  logic                     write_begin_i,
    input  logic                     write_end_i,
    input  logic                     v2c_valid_i,
    input  logic [V2C_VEC_WIDTH-1:0] v2c_msg_vec_i,
    input  logic                     wr_stall_i,
    output logic [ADDR_WIDTH-1:0]    waddr_portA_o,
    output logic [V2C_VEC_WIDTH-1:0] wdata_portA_o,
    output logic                     wen_portA_o,
    output logic                     busy_o,
    output logic                     done_o,
    output logic [CNT_WIDTH-1:0]     wr_cnt_o,
    output logic                     err_ovf_o
);

    wb_state_e                r_state;
    logic [ADDR_WIDTH-1:0]    r_ptr;
    logic [ADDR_WIDTH-1:0]    r_waddr_q;
    logic [V2C_VEC_WIDTH-1:0] r_wdata_q;
    logic [CNT_WIDTH-1:0]     r_wr_cnt;
    logic                     r_err_ovf;

    logic                     w_fifo_full;
    logic                     w_fifo_empty;
    logic [V2C_VEC_WIDTH-1:0] w_fifo_head;
    logic                     w_issue_ok;
    logic                     w_push_ok;
    logic                     w_discard;
    logic                     w_wen;
    logic                     w_pop;
    logic                     w_push;
    logic                     w_drop;
    logic                     w_start;
    logic                     w_last_addr;

`ifdef MSGPASS_WB_ADDR_LIMIT_EN
    logic r_limit_hit;

    // Address limit reached: no more issues, pushes refused, drain discards.
    assign w_issue_ok = !r_limit_hit;
    assign w_push_ok  = (r_state == WRITE) && !r_limit_hit;
    assign w_discard  = (r_state == DRAIN) && r_limit_hit && !w_fifo_empty;
`else
    assign w_issue_ok = 1'b1;
    assign w_push_ok  = (r_state == WRITE);
    assign w_discard  = 1'b0;
`endif

    assign w_start     = (r_state == IDLE) && write_begin_i;
    assign w_last_addr = (r_ptr == ADDR_WIDTH'(BUFF_DEPTH - 1));
    assign w_wen       = (r_state != IDLE) && !w_fifo_empty && !wr_stall_i && w_issue_ok;
    assign w_pop       = w_wen || w_discard;
    // A full queue still accepts a vector when the head leaves the same cycle.
    assign w_push      = v2c_valid_i && w_push_ok && (!w_fifo_full || w_pop);
    assign w_drop      = v2c_valid_i && !w_push;

    msgpass_wb_fifo #(
        .W     (V2C_VEC_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .sys_clk (sys_clk),
        .rstn    (rstn),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_data  (v2c_msg_vec_i),
        .o_head  (w_fifo_head),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty)
    );

    // Session FSM: begin beats end in IDLE; begin ignored once a session runs.
    always_ff @(posedge sys_clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= IDLE;
        end else begin
            case (r_state)
                IDLE:    if (write_begin_i) r_state <= WRITE;
                WRITE:   if (write_end_i)   r_state <= DRAIN;
                DRAIN:   if (w_fifo_empty)  r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    // Address pointer, word counter, held port values and sticky overflow.
    always_ff @(posedge sys_clk or negedge rstn) begin
        if (!rstn) begin
            r_ptr     <= '0;
            r_wr_cnt  <= '0;
            r_waddr_q <= '0;
            r_wdata_q <= '0;
            r_err_ovf <= 1'b0;
        end else begin
            if (w_start) begin
                r_ptr    <= '0;
                r_wr_cnt <= '0;
            end else if (w_wen) begin
                r_ptr     <= w_last_addr ? '0 : r_ptr + ADDR_WIDTH'(1);
                r_waddr_q <= r_ptr;
                r_wdata_q <= w_fifo_head;
                if (r_wr_cnt != '1) r_wr_cnt <= r_wr_cnt + CNT_WIDTH'(1);
            end
            if (w_drop) r_err_ovf <= 1'b1;
        end
    end

`ifdef MSGPASS_WB_ADDR_LIMIT_EN
    // Latch that the top address has been written; cleared by a new session.
    always_ff @(posedge sys_clk or negedge rstn) begin
        if (!rstn)                     r_limit_hit <= 1'b0;
        else if (w_start)              r_limit_hit <= 1'b0;
        else if (w_wen && w_last_addr) r_limit_hit <= 1'b1;
    end
`endif

    // Port A shows the live write when enabled, otherwise the last write.
    assign wen_portA_o   = w_wen ? MSGPASS_BUFF_WR_ENABLE : MSGPASS_BUFF_WR_DISABLE;
    assign waddr_portA_o = w_wen ? r_ptr : r_waddr_q;
    assign wdata_portA_o = w_wen ? w_fifo_head : r_wdata_q;
    assign busy_o        = (r_state != IDLE);
    assign done_o        = (r_state == DRAIN) && w_fifo_empty;
    assign wr_cnt_o      = r_wr_cnt;
    assign err_ovf_o     = r_err_ovf;

endmodule

// File: tb/tb_msgpass_buff_writer.sv
// Directed bench for msgpass_buff_writer. Inputs change 1ns after the rising
// edge and outputs are sampled 2ns after it.
// Honours MSGPASS_WB_ADDR_LIMIT_EN in the wrap scenario.
module tb_msgpass_buff_writer;

    localparam int VW = 20;
    localparam int AW = 3;
    localparam int CW = 8;

    logic          sys_clk = 1'b0;
    logic          rstn = 1'b0;
    logic          write_begin_i = 1'b0;
    logic          write_end_i = 1'b0;
    logic          v2c_valid_i = 1'b0;
    logic [VW-1:0] v2c_msg_vec_i = '0;
    logic          wr_stall_i = 1'b0;
    logic [AW-1:0] waddr_portA_o;
    logic [VW-1:0] wdata_portA_o;
    logic          wen_portA_o;
    logic          busy_o;
    logic          done_o;
    logic [CW-1:0] wr_cnt_o;
    logic          err_ovf_o;

    int errors = 0;
    int checks = 0;

    logic [AW+VW:0] got_w;
    logic [AW+VW:0] exp_w;

    msgpass_buff_writer #(
        .V2C_VEC_WIDTH (VW),
        .BUFF_DEPTH    (8),
        .ADDR_WIDTH    (AW),
        .FIFO_DEPTH    (2),
        .CNT_WIDTH     (CW)
    ) dut (
        .sys_clk       (sys_clk),
        .rstn          (rstn),
        .write_begin_i (write_begin_i),
        .write_end_i   (write_end_i),
        .v2c_valid_i   (v2c_valid_i),
        .v2c_msg_vec_i (v2c_msg_vec_i),
        .wr_stall_i    (wr_stall_i),
        .waddr_portA_o (waddr_portA_o),
        .wdata_portA_o (wdata_portA_o),
        .wen_portA_o   (wen_portA_o),
        .busy_o        (busy_o),
        .done_o        (done_o),
        .wr_cnt_o      (wr_cnt_o),
        .err_ovf_o     (err_ovf_o)
    );

    // Clock
    always #5 sys_clk = ~sys_clk;

    assign got_w = {wen_portA_o, waddr_portA_o, wdata_portA_o};

    function automatic logic [VW-1:0] vec(input int i);
        return 20'hA0000 + VW'(i);
    endfunction

    task automatic cycle();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic idle_inputs();
        write_begin_i = 1'b0;
        write_end_i   = 1'b0;
        v2c_valid_i   = 1'b0;
        v2c_msg_vec_i = '0;
        wr_stall_i    = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rstn = 1'b0;
        repeat (2) cycle();
        rstn = 1'b1;
        cycle();
    endtask

    task automatic start_session();
        write_begin_i = 1'b1;
        cycle();
        write_begin_i = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rstn = 1'b0;
        #3;
        if ({got_w, busy_o, done_o, wr_cnt_o, err_ovf_o} !== '0) begin
            errors++;
            $display("FAIL reset_outputs got=%h exp=0", {got_w, busy_o, done_o, wr_cnt_o, err_ovf_o});
        end
        checks++;
        do_reset();
        if ({busy_o, wen_portA_o} !== 2'b00) begin
            errors++; $display("FAIL reset_release got=%b exp=00", {busy_o, wen_portA_o});
        end
        checks++;
    endtask

    task automatic test_basic();
        do_reset();
        start_session();
        v2c_valid_i = 1'b1; v2c_msg_vec_i = 20'h11111; #1;
        if (got_w !== {1'b0, 3'd0, 20'h0}) begin
            errors++; $display("FAIL basic_first_idle got=%h exp=%h", got_w, {1'b0, 3'd0, 20'h0});
        end
        checks++;
        cycle(); v2c_msg_vec_i = 20'h22222; #1;
        if (got_w !== {1'b1, 3'd0, 20'h11111}) begin
            errors++; $display("FAIL basic_write0 got=%h exp=%h", got_w, {1'b1, 3'd0, 20'h11111});
        end
        checks++;
        cycle(); v2c_msg_vec_i = 20'h33333; #1;
        if (got_w !== {1'b1, 3'd1, 20'h22222}) begin
            errors++; $display("FAIL basic_write1 got=%h exp=%h", got_w, {1'b1, 3'd1, 20'h22222});
        end
        checks++;
        cycle(); v2c_valid_i = 1'b0; write_end_i = 1'b1; #1;
        if (got_w !== {1'b1, 3'd2, 20'h33333}) begin
            errors++; $display("FAIL basic_write2 got=%h exp=%h", got_w, {1'b1, 3'd2, 20'h33333});
        end
        checks++;
        cycle(); write_end_i = 1'b0; #1;
        if ({got_w, done_o, busy_o, wr_cnt_o} !== {1'b0, 3'd2, 20'h33333, 1'b1, 1'b1, 8'd3}) begin
            errors++;
            $display("FAIL basic_done got=%h exp=%h", {got_w, done_o, busy_o, wr_cnt_o},
                     {1'b0, 3'd2, 20'h33333, 1'b1, 1'b1, 8'd3});
        end
        checks++;
        cycle(); #1;
        if ({done_o, busy_o, err_ovf_o, wr_cnt_o} !== {3'b000, 8'd3}) begin
            errors++; $display("FAIL basic_idle got=%h exp=%h", {done_o, busy_o, err_ovf_o, wr_cnt_o}, {3'b000, 8'd3});
        end
        checks++;
    endtask

    task automatic test_wrap();
        logic exp_wen;
        do_reset();
        start_session();
        for (int i = 0; i <= 10; i++) begin
            if (i < 10) begin
                v2c_valid_i = 1'b1; v2c_msg_vec_i = vec(i);
            end else begin
                v2c_valid_i = 1'b0; write_end_i = 1'b1;
            end
            #1;
`ifdef MSGPASS_WB_ADDR_LIMIT_EN
            exp_wen = (i >= 1) && (i <= 8);
            if (i == 0)       exp_w = '0;
            else if (exp_wen) exp_w = {1'b1, 3'((i - 1) % 8), vec(i - 1)};
            else              exp_w = {1'b0, 3'd7, vec(7)};
`else
            exp_wen = (i >= 1);
            if (exp_wen) exp_w = {1'b1, 3'((i - 1) % 8), vec(i - 1)};
            else         exp_w = '0;
`endif
            if (got_w !== exp_w) begin
                errors++; $display("FAIL wrap_write i=%0d got=%h exp=%h", i, got_w, exp_w);
            end
            checks++;
            cycle();
        end
        write_end_i = 1'b0;
        #1;
`ifdef MSGPASS_WB_ADDR_LIMIT_EN
        if ({wen_portA_o, done_o} !== 2'b00) begin
            errors++; $display("FAIL wrap_discard got=%b exp=00", {wen_portA_o, done_o});
        end
        checks++;
        cycle(); #1;
        if ({done_o, wr_cnt_o, err_ovf_o} !== {1'b1, 8'd8, 1'b1}) begin
            errors++; $display("FAIL wrap_end got=%h exp=%h", {done_o, wr_cnt_o, err_ovf_o}, {1'b1, 8'd8, 1'b1});
        end
        checks++;
`else
        if ({done_o, wr_cnt_o, err_ovf_o} !== {1'b1, 8'd10, 1'b0}) begin
            errors++; $display("FAIL wrap_end got=%h exp=%h", {done_o, wr_cnt_o, err_ovf_o}, {1'b1, 8'd10, 1'b0});
        end
        checks++;
`endif
    endtask

    task automatic test_stall();
        do_reset();
        start_session();
        wr_stall_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            v2c_valid_i = (i < 3); v2c_msg_vec_i = (i < 3) ? vec(16 + i) : '0;
            #1;
            if ({wen_portA_o, err_ovf_o} !== {1'b0, (i == 3)}) begin
                errors++; $display("FAIL stall_hold i=%0d got=%b exp=%b", i, {wen_portA_o, err_ovf_o}, {1'b0, (i == 3)});
            end
            checks++;
            cycle();
        end
        wr_stall_i = 1'b0; v2c_valid_i = 1'b0; #1;
        if (got_w !== {1'b1, 3'd0, vec(16)}) begin
            errors++; $display("FAIL stall_release0 got=%h exp=%h", got_w, {1'b1, 3'd0, vec(16)});
        end
        checks++;
        cycle(); write_end_i = 1'b1; #1;
        if (got_w !== {1'b1, 3'd1, vec(17)}) begin
            errors++; $display("FAIL stall_release1 got=%h exp=%h", got_w, {1'b1, 3'd1, vec(17)});
        end
        checks++;
        cycle(); write_end_i = 1'b0; #1;
        if ({wen_portA_o, done_o, wr_cnt_o, err_ovf_o} !== {2'b01, 8'd2, 1'b1}) begin
            errors++;
            $display("FAIL stall_done got=%h exp=%h", {wen_portA_o, done_o, wr_cnt_o, err_ovf_o}, {2'b01, 8'd2, 1'b1});
        end
        checks++;
    endtask

    task automatic test_corner_pulses();
        do_reset();
        v2c_valid_i = 1'b1; v2c_msg_vec_i = 20'h5A5A5; #1;
        if (wen_portA_o !== 1'b0) begin
            errors++; $display("FAIL idle_valid_wen got=%b exp=0", wen_portA_o);
        end
        checks++;
        cycle(); v2c_valid_i = 1'b0; #1;
        if ({wen_portA_o, busy_o, err_ovf_o} !== 3'b001) begin
            errors++; $display("FAIL idle_valid_err got=%b exp=001", {wen_portA_o, busy_o, err_ovf_o});
        end
        checks++;
        write_begin_i = 1'b1; write_end_i = 1'b1;
        cycle(); write_begin_i = 1'b0; write_end_i = 1'b0; #1;
        if ({busy_o, done_o} !== 2'b10) begin
            errors++; $display("FAIL begin_end_start got=%b exp=10", {busy_o, done_o});
        end
        checks++;
        cycle(); #1;
        if ({busy_o, done_o} !== 2'b10) begin
            errors++; $display("FAIL begin_end_stay got=%b exp=10", {busy_o, done_o});
        end
        checks++;
        write_end_i = 1'b1;
        cycle(); write_end_i = 1'b0; #1;
        if ({busy_o, done_o, wr_cnt_o} !== {2'b11, 8'd0}) begin
            errors++; $display("FAIL empty_session_done got=%h exp=%h", {busy_o, done_o, wr_cnt_o}, {2'b11, 8'd0});
        end
        checks++;
        cycle(); #1;
        if ({busy_o, done_o} !== 2'b00) begin
            errors++; $display("FAIL empty_session_idle got=%b exp=00", {busy_o, done_o});
        end
        checks++;
    endtask

    task automatic test_valid_with_end();
        do_reset();
        start_session();
        v2c_valid_i = 1'b1; v2c_msg_vec_i = 20'hBEEF1; write_end_i = 1'b1; #1;
        if (wen_portA_o !== 1'b0) begin
            errors++; $display("FAIL vend_pre got=%b exp=0", wen_portA_o);
        end
        checks++;
        cycle(); v2c_valid_i = 1'b0; write_end_i = 1'b0; #1;
        if ({got_w, done_o} !== {1'b1, 3'd0, 20'hBEEF1, 1'b0}) begin
            errors++; $display("FAIL vend_write got=%h exp=%h", {got_w, done_o}, {1'b1, 3'd0, 20'hBEEF1, 1'b0});
        end
        checks++;
        cycle(); #1;
        if ({done_o, wr_cnt_o, err_ovf_o} !== {1'b1, 8'd1, 1'b0}) begin
            errors++; $display("FAIL vend_done got=%h exp=%h", {done_o, wr_cnt_o, err_ovf_o}, {1'b1, 8'd1, 1'b0});
        end
        checks++;
    endtask

    task automatic test_reset_mid_session();
        do_reset();
        start_session();
        v2c_valid_i = 1'b1; v2c_msg_vec_i = 20'h0C0C0;
        cycle(); v2c_msg_vec_i = 20'h0C0C1;
        cycle(); v2c_msg_vec_i = 20'h0C0C2; wr_stall_i = 1'b1;
        cycle(); v2c_valid_i = 1'b0; #1;
        if ({busy_o, wen_portA_o, wdata_portA_o, wr_cnt_o} !== {2'b10, 20'h0C0C0, 8'd1}) begin
            errors++;
            $display("FAIL mid_pre got=%h exp=%h", {busy_o, wen_portA_o, wdata_portA_o, wr_cnt_o},
                     {2'b10, 20'h0C0C0, 8'd1});
        end
        checks++;
        rstn = 1'b0; #1;
        if ({got_w, busy_o, done_o, wr_cnt_o, err_ovf_o} !== '0) begin
            errors++;
            $display("FAIL mid_reset got=%h exp=0", {got_w, busy_o, done_o, wr_cnt_o, err_ovf_o});
        end
        checks++;
        cycle(); rstn = 1'b1; wr_stall_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cycle();
            if ({wen_portA_o, busy_o} !== 2'b00) begin
                errors++; $display("FAIL mid_after i=%0d got=%b exp=00", i, {wen_portA_o, busy_o});
            end
            checks++;
        end
        start_session(); #1;
        if ({wen_portA_o, busy_o} !== 2'b01) begin
            errors++; $display("FAIL mid_newsession got=%b exp=01", {wen_portA_o, busy_o});
        end
        checks++;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_wrap();
        test_stall();
        test_corner_pulses();
        test_valid_with_end();
        test_reset_mid_session();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
